// File: rtl/flash_resp_pkg.sv
// Shared types, widths and the synthetic data pattern for the flash read responder.
package flash_resp_pkg;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int BURST_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STALL,
        ST_GRANT,
        ST_LAT,
        ST_BURST
    } state_t;

    // Four consecutive byte values starting at the low address byte, wrapping at 8 bits.
    function automatic logic [DATA_W-1:0] pattern(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

endpackage

// File: rtl/flash_resp_store.sv
// Word lookup with a registered read port; holds its output between reads.
// Macro FLASH_RESP_MEMFILE_EN selects a preloaded memory instead of the direct pattern.
module flash_resp_store
    import flash_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter     MEM_FILE   = "flash_init.hex"
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_word;
    logic [DATA_W-1:0] r_data;

`ifdef FLASH_RESP_MEMFILE_EN
    logic [DATA_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
    logic              w_unused_addr;

    initial begin
        for (int i = 0; i < (2**DEPTH_LOG2); i++) begin
            r_mem[i] = pattern(8'(i));
        end
    end

    assign w_word        = r_mem[i_addr[DEPTH_LOG2-1:0]];
    assign w_unused_addr = ^i_addr;
`else
    logic w_unused_addr;

    assign w_word        = pattern(i_addr[7:0]);
    assign w_unused_addr = ^i_addr[ADDR_W-1:8];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= '0;
        end else if (i_en) begin
            r_data <= w_word;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/flash_read_responder.sv
// Avalon-MM read-only flash stand-in: waitrequest stall, fixed read latency, burst return.
// Define FLASH_RESP_MEMFILE_EN to serve data from a preloaded memory instead of the pattern.
module flash_read_responder
    import flash_resp_pkg::*;
#(
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int DEPTH_LOG2   = 10,
    parameter     MEM_FILE     = "flash_init.hex"
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flash_mem_read,
    input  logic               flash_mem_write,
    input  logic [ADDR_W-1:0]  flash_mem_address,
    input  logic [BURST_W-1:0] flash_mem_burstcount,
    input  logic [3:0]         flash_mem_byteenable,
    input  logic [DATA_W-1:0]  flash_mem_writedata,
    output logic               flash_mem_waitrequest,
    output logic [DATA_W-1:0]  flash_mem_readdata,
    output logic               flash_mem_readdatavalid,
    output logic [15:0]        read_count,
    output logic               write_err,
    output logic               proto_err
);

    // IDLE already spends one waitrequest-high cycle, so STALL covers the rest.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES >= 2) ? 4'(WAIT_CYCLES - 2) : 4'd0;
    // The final LAT cycle issues the first beat into the registered store.
    localparam logic [3:0] LAT_LOAD  = 4'(READ_LATENCY - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_issue;
    logic               w_drop;
    logic               w_wr_seen;
    logic [3:0]         r_wait;
    logic [3:0]         r_lat;
    logic [ADDR_W-1:0]  r_addr;
    logic [BURST_W-1:0] r_beats;
    logic               r_rdv;
    logic [15:0]        r_read_count;
    logic               r_write_err;
    logic               r_proto_err;
    logic [DATA_W-1:0]  w_store_data;
    logic               w_unused_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_issue   = 1'b0;
        w_drop    = 1'b0;
        w_wr_seen = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_wr_seen = flash_mem_write;
                if (flash_mem_read) begin
                    if (WAIT_CYCLES == 0) begin
                        w_accept = 1'b1;
                        w_next   = ST_LAT;
                    end else if (WAIT_CYCLES == 1) begin
                        w_next = ST_GRANT;
                    end else begin
                        w_next = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                w_wr_seen = flash_mem_write;
                if (!flash_mem_read) begin
                    w_drop = 1'b1;
                    w_next = ST_IDLE;
                end else if (r_wait == 4'd0) begin
                    w_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_wr_seen = flash_mem_write;
                if (flash_mem_read) begin
                    w_accept = 1'b1;
                    w_next   = ST_LAT;
                end else begin
                    w_drop = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_LAT: begin
                if (r_lat == 4'd0) begin
                    w_issue = 1'b1;
                    w_next  = (r_beats == BURST_W'(1)) ? ST_IDLE : ST_BURST;
                end
            end
            ST_BURST: begin
                w_issue = 1'b1;
                if (r_beats == BURST_W'(1)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counters and beat address: only meaningful once a burst has been accepted.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE) begin
            r_wait <= WAIT_LOAD;
        end else if (r_state == ST_STALL && r_wait != 4'd0) begin
            r_wait <= r_wait - 4'd1;
        end

        if (w_accept) begin
            r_lat   <= LAT_LOAD;
            r_addr  <= flash_mem_address;
            r_beats <= (flash_mem_burstcount == '0) ? BURST_W'(1) : flash_mem_burstcount;
        end else begin
            if (r_state == ST_LAT && r_lat != 4'd0) begin
                r_lat <= r_lat - 4'd1;
            end
            if (w_issue) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_beats <= r_beats - BURST_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdv        <= 1'b0;
            r_read_count <= '0;
            r_write_err  <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            r_rdv <= w_issue;
            if (w_accept) begin
                r_read_count <= r_read_count + 16'd1;
            end
            if (w_wr_seen) begin
                r_write_err <= 1'b1;
            end
            if (w_drop) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    flash_resp_store #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .MEM_FILE   (MEM_FILE)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_issue),
        .i_addr  (r_addr),
        .o_data  (w_store_data)
    );

    assign flash_mem_waitrequest   = !reset_n ||
                                     !((r_state == ST_GRANT) ||
                                       (r_state == ST_IDLE && WAIT_CYCLES == 0));
    assign flash_mem_readdata      = w_store_data;
    assign flash_mem_readdatavalid = r_rdv;
    assign read_count              = r_read_count;
    assign write_err               = r_write_err;
    assign proto_err               = r_proto_err;

    assign w_unused_ok = ^{flash_mem_byteenable, flash_mem_writedata};

endmodule

// File: tb/tb_flash_read_responder.sv
// Self-checking bench for flash_read_responder: directed cases plus randomized bursts.
module tb_flash_read_responder;

    localparam int WAITC = 2;
    localparam int LAT   = 3;
    localparam int WAIT_BOUND = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [22:0] addr = '0;
    logic [5:0]  bc = '0;
    logic [3:0]  be = 4'hF;
    logic [31:0] wd = '0;
    logic        wreq;
    logic [31:0] rdata;
    logic        rdv;
    logic [15:0] rcount;
    logic        werr;
    logic        perr;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;
    logic exp_werr = 1'b0;
    logic exp_perr = 1'b0;

    flash_read_responder #(
        .WAIT_CYCLES  (WAITC),
        .READ_LATENCY (LAT)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .flash_mem_read          (rd),
        .flash_mem_write         (wr),
        .flash_mem_address       (addr),
        .flash_mem_burstcount    (bc),
        .flash_mem_byteenable    (be),
        .flash_mem_writedata     (wd),
        .flash_mem_waitrequest   (wreq),
        .flash_mem_readdata      (rdata),
        .flash_mem_readdatavalid (rdv),
        .read_count              (rcount),
        .write_err               (werr),
        .proto_err               (perr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of the word is (address low byte + k) mod 256.
    function automatic logic [31:0] model_word(input int unsigned a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = 8'((a + k) % 256);
        end
        return w;
    endfunction

    task automatic do_read(input int unsigned a, input int burst, input bit with_wr,
                           input int abort_beat);
        int n;
        int k;
        int beat;
        logic [31:0] last;
        n = (burst == 0) ? 1 : burst;
        last = '0;
        addr = 23'(a);
        bc = 6'(burst);
        be = 4'($urandom_range(0, 15));
        wd = $urandom;
        rd = 1'b1;
        wr = with_wr;
        k = 0;
        while (wreq === 1'b1 && k < WAIT_BOUND) begin
            k++;
            tick();
        end
        check("wait_cycles", k, WAITC);
        if (k >= WAIT_BOUND) begin
            rd = 1'b0;
            wr = 1'b0;
            return;
        end
        tick();
        rd = 1'b0;
        wr = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        if (with_wr) exp_werr = 1'b1;
        check("read_count", rcount, exp_count);
        beat = 0;
        for (int j = 1; j <= LAT + n; j++) begin
            tick();
            if (j < LAT) begin
                check("rdv_latency", rdv, 1'b0);
            end else if (j < LAT + n) begin
                last = model_word((a + beat) % (1 << 23));
                check("rdv_beat", rdv, 1'b1);
                check("rdata_beat", rdata, last);
                beat++;
                if (abort_beat != 0 && beat == abort_beat) begin
                    reset_n = 1'b0;
                    #1;
                    check("rst_rdv", rdv, 1'b0);
                    check("rst_wreq", wreq, 1'b1);
                    check("rst_rdata", rdata, 32'h0);
                    exp_count = 0;
                    exp_werr = 1'b0;
                    exp_perr = 1'b0;
                    return;
                end
            end else begin
                check("rdv_after", rdv, 1'b0);
                check("rdata_hold", rdata, last);
            end
        end
    endtask

    initial begin
        int unsigned ra;
        int rb;
        bit rw;

        // Reset values
        repeat (3) tick();
        check("reset_wreq", wreq, 1'b1);
        check("reset_rdv", rdv, 1'b0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_count", rcount, 16'h0);
        check("reset_werr", werr, 1'b0);
        check("reset_perr", perr, 1'b0);
        reset_n = 1'b1;
        tick();
        check("idle_wreq", wreq, 1'b1);

        // Single beat, burst across the address wrap, burstcount zero
        do_read(50, 1, 1'b0, 0);
        do_read(23'h7FFFFE, 4, 1'b0, 0);
        do_read(23'h10, 0, 1'b0, 0);

        // Write-only request flags an error and stays idle
        wr = 1'b1;
        tick();
        wr = 1'b0;
        exp_werr = 1'b1;
        check("write_only_err", werr, exp_werr);
        check("write_only_rdv", rdv, 1'b0);

        // Read and write together: read is served, flag sticks
        do_read(0, 1, 1'b1, 0);
        check("rw_werr", werr, exp_werr);

        // Read withdrawn during the stall
        addr = 23'h44;
        bc = 6'd2;
        rd = 1'b1;
        tick();
        check("stall_wreq", wreq, 1'b1);
        rd = 1'b0;
        tick();
        exp_perr = 1'b1;
        check("proto_err_set", perr, exp_perr);
        for (int i = 0; i < 6; i++) begin
            check("proto_no_rdv", rdv, 1'b0);
            tick();
        end
        check("proto_count", rcount, exp_count);
        do_read(23'h80, 2, 1'b0, 0);

        // Randomized bursts with idle gaps
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 23'h7FFFFF - $urandom_range(0, 3);
            else ra = $urandom_range(0, 23'h7FFFFF);
            rb = $urandom_range(0, 9);
            rw = ($urandom_range(0, 7) == 0);
            do_read(ra, rb, rw, 0);
            repeat ($urandom_range(0, 3)) tick();
        end
        check("rand_werr", werr, exp_werr);
        check("rand_perr", perr, exp_perr);
        check("rand_count", rcount, exp_count);

        // Reset in the middle of a burst
        do_read(23'h200, 4, 1'b0, 2);
        tick();
        check("in_reset_rdv", rdv, 1'b0);
        reset_n = 1'b1;
        tick();
        check("post_rst_count", rcount, exp_count);
        check("post_rst_werr", werr, exp_werr);
        check("post_rst_perr", perr, exp_perr);
        check("post_rst_wreq", wreq, 1'b1);
        check("post_rst_rdv", rdv, 1'b0);
        do_read(23'h33, 3, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
